// File: rtl/sram_pattern_sequencer.sv
// SRAM self-test sequencer: full write pass then read-back pass against a
// selectable data pattern, reporting mismatch count and first failing word.
module sram_pattern_sequencer #(
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned LAST_ADDR = 2**19 - 1,
   parameter int unsigned ERR_W     = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [1:0]        pattern_sel_i,
   input  logic [DATA_W-1:0] pattern_val_i,
   output logic              running_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ERR_W-1:0]  err_count_o,
   output logic [ADDR_W-1:0] first_err_addr_o,
   output logic [DATA_W-1:0] first_err_data_o,
   output logic              ctrl_start_o,
   output logic              ctrl_rw_o,
   output logic [ADDR_W-1:0] ctrl_addr_o,
   output logic [DATA_W-1:0] ctrl_wdata_o,
   input  logic [DATA_W-1:0] ctrl_rdata_i,
   input  logic              ctrl_rd_ready_i,
   input  logic              ctrl_wr_done_i,
   input  logic              ctrl_busy_i
);

   localparam int unsigned SETTLE_W   = 3;
   localparam logic [SETTLE_W-1:0] SETTLE_CYC = SETTLE_W'(4);
   localparam logic [ADDR_W-1:0]   LAST_A     = ADDR_W'(LAST_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ISSUE,
      S_WR_WAIT,
      S_RD_WAIT,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [SETTLE_W-1:0]   settle_q;
   logic [1:0]            sel_q, sel_d;
   logic [DATA_W-1:0]     val_q, val_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  rw_q, rw_d;
   logic                  cstart_q, cstart_d;
   logic                  running_q, running_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic [ADDR_W-1:0]     ferr_addr_q, ferr_addr_d;
   logic [DATA_W-1:0]     ferr_data_q, ferr_data_d;

   logic                  settled_c;
   logic                  start_ok_c;
   logic                  last_c;
   logic [ADDR_W-1:0]     next_addr_c;
   logic                  mismatch_c;

   // Pattern used for both write data and expected read data.
   function automatic logic [DATA_W-1:0] pat(input logic [1:0]        sel,
                                             input logic [DATA_W-1:0] val,
                                             input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = val;
      unique case (sel)
         2'd0: r = val;
         2'd1: r = DATA_W'(a);
         2'd2: r = ~DATA_W'(a);
         default: begin
            for (int i = 0; i < int'(DATA_W); i++) begin
               r[i] = ((i % 2) == 0) ^ a[0];
            end
         end
      endcase
      return r;
   endfunction

   assign settled_c   = (settle_q == SETTLE_CYC);
   assign start_ok_c  = start_i && settled_c;
   assign last_c      = (addr_q == LAST_A);
   assign next_addr_c = addr_q + ADDR_W'(1);
   assign mismatch_c  = (ctrl_rdata_i != pat(sel_q, val_q, addr_q));

   // State register and post-reset settle counter (controller has no reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
      end else begin
         state_q <= state_d;
         if (!settled_c) begin
            settle_q <= settle_q + SETTLE_W'(1);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start_ok_c) state_d = S_WR_ISSUE;
         S_WR_ISSUE: if (!ctrl_busy_i) state_d = S_WR_WAIT;
         S_WR_WAIT:  if (ctrl_wr_done_i && last_c) state_d = S_RD_WAIT;
         S_RD_WAIT:  if (ctrl_rd_ready_i && last_c) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values. A done pulse means busy drops on the
   // following cycle, so the next access is issued on the same edge.
   always_comb begin
      sel_d       = sel_q;
      val_d       = val_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rw_d        = rw_q;
      cstart_d    = 1'b0;
      running_d   = running_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_d       = err_q;
      ferr_addr_d = ferr_addr_q;
      ferr_data_d = ferr_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok_c) begin
               sel_d       = pattern_sel_i;
               val_d       = pattern_val_i;
               addr_d      = '0;
               err_d       = '0;
               ferr_addr_d = '0;
               ferr_data_d = '0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
            end
         end
         S_WR_ISSUE: begin
            if (!ctrl_busy_i) begin
               cstart_d  = 1'b1;
               rw_d      = 1'b0;
               wdata_d   = pat(sel_q, val_q, addr_q);
               running_d = 1'b1;
            end
         end
         S_WR_WAIT: begin
            if (ctrl_wr_done_i) begin
               cstart_d = 1'b1;
               if (last_c) begin
                  addr_d = '0;
                  rw_d   = 1'b1;
               end else begin
                  addr_d  = next_addr_c;
                  rw_d    = 1'b0;
                  wdata_d = pat(sel_q, val_q, next_addr_c);
               end
            end
         end
         S_RD_WAIT: begin
            if (ctrl_rd_ready_i) begin
               if (mismatch_c) begin
                  if (err_q == '0) begin
                     ferr_addr_d = addr_q;
                     ferr_data_d = ctrl_rdata_i;
                  end
                  if (err_q != '1) begin
                     err_d = err_q + ERR_W'(1);
                  end
               end
               if (last_c) begin
                  running_d = 1'b0;
                  done_d    = 1'b1;
                  pass_d    = (err_d == '0);
               end else begin
                  addr_d   = next_addr_c;
                  rw_d     = 1'b1;
                  cstart_d = 1'b1;
               end
            end
         end
         S_DONE: ;
         default: ;
      endcase
   end

   // Registered outputs and working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q       <= '0;
         val_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rw_q        <= 1'b0;
         cstart_q    <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
      end else begin
         sel_q       <= sel_d;
         val_q       <= val_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rw_q        <= rw_d;
         cstart_q    <= cstart_d;
         running_q   <= running_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         ferr_addr_q <= ferr_addr_d;
         ferr_data_q <= ferr_data_d;
      end
   end

   assign running_o        = running_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign err_count_o      = err_q;
   assign first_err_addr_o = ferr_addr_q;
   assign first_err_data_o = ferr_data_q;
   assign ctrl_start_o     = cstart_q;
   assign ctrl_rw_o        = rw_q;
   assign ctrl_addr_o      = addr_q;
   assign ctrl_wdata_o     = wdata_q;

endmodule

// File: tb/tb_sram_pattern_sequencer.sv
// Directed bench: behavioural 5-cycle SRAM controller with fault injection
// driving a 16-word, 2-bit error counter instance of the sequencer.
module tb_sram_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_i = 1'b0;
   logic [1:0] pattern_sel_i = 2'd0;
   logic [7:0] pattern_val_i = 8'd0;
   logic       running_o, done_o, pass_o;
   logic [1:0] err_count_o;
   logic [7:0] first_err_addr_o, first_err_data_o;
   logic       ctrl_start_o, ctrl_rw_o;
   logic [7:0] ctrl_addr_o, ctrl_wdata_o;
   logic [7:0] ctrl_rdata_i;
   logic       ctrl_rd_ready_i, ctrl_wr_done_i, ctrl_busy_i;

   // Controller model state
   logic       busy_m = 1'b0, done_m = 1'b0, rdy_m = 1'b0, rw_m = 1'b0;
   logic [2:0] cnt_m = 3'd0;
   logic [3:0] a_m = 4'd0;
   logic [7:0] wd_m = 8'd0, rdata_m = 8'd0;
   logic [7:0] mem    [16];
   logic [7:0] wr_log [16];
   logic [7:0] and_m  [16];
   logic [7:0] xor_m  [16];
   logic       stray_rd = 1'b0;
   logic       prev_start = 1'b0;
   int         proto_err = 0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign ctrl_rdata_i    = rdata_m;
   assign ctrl_rd_ready_i = rdy_m | stray_rd;
   assign ctrl_wr_done_i  = done_m;
   assign ctrl_busy_i     = busy_m;

   sram_pattern_sequencer #(
      .ADDR_W(8), .DATA_W(8), .LAST_ADDR(15), .ERR_W(2)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .pattern_sel_i(pattern_sel_i), .pattern_val_i(pattern_val_i),
      .running_o(running_o), .done_o(done_o), .pass_o(pass_o),
      .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
      .first_err_data_o(first_err_data_o), .ctrl_start_o(ctrl_start_o),
      .ctrl_rw_o(ctrl_rw_o), .ctrl_addr_o(ctrl_addr_o),
      .ctrl_wdata_o(ctrl_wdata_o), .ctrl_rdata_i(ctrl_rdata_i),
      .ctrl_rd_ready_i(ctrl_rd_ready_i), .ctrl_wr_done_i(ctrl_wr_done_i),
      .ctrl_busy_i(ctrl_busy_i)
   );

   // Start sampled -> busy next 4 cycles, done pulse in 4th, busy drops after.
   always @(posedge clk) begin
      done_m <= 1'b0;
      rdy_m  <= 1'b0;
      if (!busy_m) begin
         if (ctrl_start_o) begin
            busy_m <= 1'b1;
            cnt_m  <= 3'd1;
            rw_m   <= ctrl_rw_o;
            a_m    <= ctrl_addr_o[3:0];
            wd_m   <= ctrl_wdata_o;
         end
      end else if (cnt_m == 3'd3) begin
         cnt_m <= 3'd4;
         if (rw_m) begin
            rdy_m   <= 1'b1;
            rdata_m <= (mem[a_m] & and_m[a_m]) ^ xor_m[a_m];
         end else begin
            done_m     <= 1'b1;
            mem[a_m]   <= wd_m;
            wr_log[a_m] <= wd_m;
         end
      end else if (cnt_m == 3'd4) begin
         busy_m <= 1'b0;
      end else begin
         cnt_m <= cnt_m + 3'd1;
      end
   end

   // Request must never overlap busy and must last one cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ctrl_start_o && busy_m) proto_err = proto_err + 1;
         if (ctrl_start_o && prev_start) proto_err = proto_err + 1;
      end
      prev_start = ctrl_start_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < 16; i++) begin
         and_m[i] = 8'hFF;
         xor_m[i] = 8'h00;
      end
   endtask

   // start_i is sampled at edge 0; returns the cycle of first request and done.
   task automatic go(input logic [1:0] sel, input logic [7:0] val,
                     input int stray_start, input int stray_rd_at,
                     output int done_cyc, output int first_start,
                     output logic run0, output logic run1, output logic done0);
      @(negedge clk);
      start_i = 1'b1; pattern_sel_i = sel; pattern_val_i = val;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      run0 = running_o; done0 = done_o; run1 = 1'b0;
      done_cyc = -1; first_start = -1;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (n == 1) run1 = running_o;
         if (first_start < 0 && ctrl_start_o) first_start = n;
         start_i  = (n == stray_start);
         stray_rd = (n == stray_rd_at);
         if (done_o) begin
            done_cyc = n;
            break;
         end
      end
      start_i = 1'b0; stray_rd = 1'b0;
   endtask

   initial begin
      int   dc, fs;
      logic r0, r1, d0;
      clear_faults();
      repeat (3) @(negedge clk);
      chk("rst_running", running_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_pass", pass_o, 0);
      chk("rst_cstart", ctrl_start_o, 0);
      chk("rst_rw", ctrl_rw_o, 0);
      chk("rst_addr", ctrl_addr_o, 0);
      chk("rst_wdata", ctrl_wdata_o, 0);
      chk("rst_err", err_count_o, 0);
      chk("rst_faddr", first_err_addr_o, 0);
      chk("rst_fdata", first_err_data_o, 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // Clean pass, address pattern
      go(2'd1, 8'h00, 0, 0, dc, fs, r0, r1, d0);
      chk("t1_first_start", fs, 1);
      chk("t1_running_c0", r0, 0);
      chk("t1_running_c1", r1, 1);
      chk("t1_done_cycle", dc, 161);
      chk("t1_running_at_done", running_o, 0);
      chk("t1_pass", pass_o, 1);
      chk("t1_err", err_count_o, 0);
      for (int i = 0; i < 16; i++) chk("t1_wdata", wr_log[i], i);
      repeat (5) @(negedge clk);
      chk("t1_done_hold", done_o, 1);
      chk("t1_pass_hold", pass_o, 1);

      // Stuck bit 3 at address 9, constant 0xFF, stray start/rd_ready
      and_m[9] = 8'hF7;
      go(2'd0, 8'hFF, 50, 3, dc, fs, r0, r1, d0);
      chk("t2_done_cleared", d0, 0);
      chk("t2_done_cycle", dc, 161);
      chk("t2_err", err_count_o, 1);
      chk("t2_faddr", first_err_addr_o, 9);
      chk("t2_fdata", first_err_data_o, 8'hF7);
      chk("t2_pass", pass_o, 0);
      chk("t2_done", done_o, 1);

      // Checkerboard with faults at 4 and 12
      clear_faults();
      xor_m[4] = 8'h01; xor_m[12] = 8'h01;
      go(2'd3, 8'h00, 0, 0, dc, fs, r0, r1, d0);
      chk("t3_done_cycle", dc, 161);
      chk("t3_err", err_count_o, 2);
      chk("t3_faddr", first_err_addr_o, 4);
      chk("t3_fdata", first_err_data_o, 8'h54);
      chk("t3_pass", pass_o, 0);
      chk("t3_wd0", wr_log[0], 8'h55);
      chk("t3_wd1", wr_log[1], 8'hAA);
      chk("t3_wd14", wr_log[14], 8'h55);
      chk("t3_wd15", wr_log[15], 8'hAA);

      // Every read corrupted, inverted-address pattern: counter saturates
      clear_faults();
      for (int i = 0; i < 16; i++) xor_m[i] = 8'hFF;
      go(2'd2, 8'h00, 0, 0, dc, fs, r0, r1, d0);
      chk("t4_done_cycle", dc, 161);
      chk("t4_err_sat", err_count_o, 3);
      chk("t4_faddr", first_err_addr_o, 0);
      chk("t4_fdata", first_err_data_o, 8'h00);
      chk("t4_pass", pass_o, 0);
      chk("t4_wd0", wr_log[0], 8'hFF);
      chk("t4_wd5", wr_log[5], 8'hFA);

      // Reset at cycle 40 mid-write
      clear_faults();
      @(negedge clk);
      start_i = 1'b1; pattern_sel_i = 2'd1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      repeat (40) @(negedge clk);
      chk("t5_running_pre", running_o, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_running", running_o, 0);
      chk("t5_addr", ctrl_addr_o, 0);
      chk("t5_wdata", ctrl_wdata_o, 0);
      chk("t5_cstart", ctrl_start_o, 0);
      chk("t5_rw", ctrl_rw_o, 0);
      chk("t5_done", done_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start_i = 1'b1;
      repeat (4) @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      chk("t5_settle_running", running_o, 0);
      chk("t5_settle_cstart", ctrl_start_o, 0);
      repeat (3) @(negedge clk);
      chk("t5_settle_idle", running_o, 0);

      // Second reset, start sampled on the 5th edge after release
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      go(2'd1, 8'h00, 0, 0, dc, fs, r0, r1, d0);
      chk("t5_first_start", fs, 1);
      chk("t5_done_cycle", dc, 161);
      chk("t5_pass", pass_o, 1);
      chk("t5_err", err_count_o, 0);

      chk("protocol", proto_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_pattern_sequencer.md
# sram_pattern_sequencer

Self-test sequencer that drives the single-port SRAM controller through a full write pass, then a full read-back pass. Each read word is compared against the pattern it was written with, and the sequencer reports an error count plus the first failing address and data. It sits between the board-level start/status logic (button, LEDs, UART report) and the SRAM controller's request/handshake ports. It owns the controller exclusively while running.

## Interface
Parameters:
- ADDR_W, 19, address width; matches the controller address bus.
- DATA_W, 8, data width; matches the controller data bus.
- LAST_ADDR, 2**19-1, highest address tested; the test covers 0..LAST_ADDR inclusive.
- ERR_W, 20, width of the error counter.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- start_i, input, 1, begin test; sampled only in IDLE with settle complete.
- pattern_sel_i, input, 2, pattern select; latched at start.
- pattern_val_i, input, DATA_W, constant pattern; latched at start.
- running_o, output, 1, test in progress.
- done_o, output, 1, test finished; held until the next start.
- pass_o, output, 1, done_o and err_count_o==0.
- err_count_o, output, ERR_W, mismatch count; saturating.
- first_err_addr_o, output, ADDR_W, address of the first mismatch.
- first_err_data_o, output, DATA_W, data read at the first mismatch.
- ctrl_start_o, output, 1, one-cycle request pulse to the controller.
- ctrl_rw_o, output, 1, 1 = read, 0 = write.
- ctrl_addr_o, output, ADDR_W, access address.
- ctrl_wdata_o, output, DATA_W, write data.
- ctrl_rdata_i, input, DATA_W, registered read data from the controller.
- ctrl_rd_ready_i, input, 1, one-cycle pulse; ctrl_rdata_i is valid in the same cycle.
- ctrl_wr_done_i, input, 1, one-cycle write-finished pulse.
- ctrl_busy_i, input, 1, controller busy.

## Operation
- Pattern function p(a), selected by pattern_sel:
  - 0: pattern_val.
  - 1: a[7:0].
  - 2: ~a[7:0].
  - 3: 8'h55 if a[0]==0, else 8'hAA.
- The same function produces both the write data and the expected read data.
- States:
  - IDLE: on start_i, latch sel/val, clear err_count, first_err_*, done_o and pass_o, set addr=0, go to WR_ISSUE.
  - WR_ISSUE: wait until ctrl_busy_i==0, then pulse ctrl_start_o with rw=0, wdata=p(addr); go to WR_WAIT.
  - WR_WAIT: on ctrl_wr_done_i, if addr==LAST_ADDR set addr=0 and go to RD_ISSUE; otherwise addr+1 and go to WR_ISSUE.
  - RD_ISSUE: same as WR_ISSUE with rw=1.
  - RD_WAIT: on ctrl_rd_ready_i, compare ctrl_rdata_i to p(addr).
    - On mismatch, increment err_count, saturating at all-ones.
    - If this is the first mismatch, capture addr and ctrl_rdata_i.
    - Then advance as in WR_WAIT; after LAST_ADDR go to DONE.
  - DONE: done_o=1 and pass_o valid; return to IDLE the next cycle. done_o, pass_o and the status outputs hold until the next start.
- ctrl_addr_o, ctrl_rw_o and ctrl_wdata_o are held stable from the issue cycle through the done pulse.
- start_i while running is ignored.
- Done pulses arriving in any state other than the matching WAIT state are ignored.
- Address arithmetic is ADDR_W-bit. The terminal check is equality with LAST_ADDR and the address never wraps past it.

## Timing
- Reset values:
  - running_o, done_o, pass_o, ctrl_start_o, ctrl_rw_o: 0.
  - ctrl_addr_o, ctrl_wdata_o, err_count_o, first_err_*: 0.
  - State: IDLE.
- Post-reset settle: the controller has no reset, so start_i is ignored for 4 cycles after rst_n deasserts. This lets any in-flight controller access drain.
- Reset mid-test: the sequencer aborts to IDLE immediately and the settle rule applies.
- ctrl_start_o is high for exactly one cycle per access and never while ctrl_busy_i==1.
- Access cost: the controller turns each access around in 4 cycles after the start pulse, and busy falls the cycle after the done pulse. Each access therefore takes 5 cycles, and back-to-back issue happens with no idle gap.
- Total latency, with start_i sampled at edge 0:
  - ctrl_start_o first high in cycle 1.
  - done_o rises at cycle 1 + 10*(LAST_ADDR+1).
- running_o is high from cycle 1 until done_o rises.

## Test plan
- Clean pass, LAST_ADDR=15, sel=1, behavioural SRAM model plus controller: writes to addresses 0..15 carry data 0x00..0x0F; reads return the same; done_o at cycle 161; pass_o=1; err_count_o=0.
- Stuck bit, model forces bit 3 to 0 at address 9, sel=0, val=0xFF: err_count_o=1, first_err_addr_o=9, first_err_data_o=0xF7, pass_o=0.
- Multiple faults, sel=3, bad addresses 4 and 12: err_count_o=2, first_err_addr_o=4; checkerboard write data alternates 0x55/0xAA.
- Protocol checks: ctrl_start_o is never high while busy; each start is exactly 1 cycle; start_i pulsed mid-test has no effect; stray ctrl_rd_ready_i during the write phase has no effect.
- Reset at cycle 40 mid-write: all outputs return to reset values immediately. start_i in the 4 cycles after release is ignored; start_i at cycle 5 after release runs a full pass with pass_o=1.
- Saturation, ERR_W=2, sel=2, all 16 reads corrupted: err_count_o=3, first_err_addr_o=0.
